// File: rtl/alu_seq_core_pkg.sv
// Shared opcode and FSM state encodings for the sequential ALU core.
package alu_seq_core_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MUL  = 3'd2,
        OP_DIV  = 3'd3,
        OP_OR   = 3'd4,
        OP_AND  = 3'd5,
        OP_NOT1 = 3'd6,
        OP_NOT2 = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/alu_seq_divider.sv
// Signed division built on an unsigned restoring divider over operand
// magnitudes. One edge loads, WIDTH edges iterate, and 'done' is then
// presented for a single cycle with the sign-fixed quotient/remainder.
module alu_seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dz
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             running_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] dsr_reg;
    logic [WIDTH-1:0] dvd_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic             dz_reg;

    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // Magnitudes of the incoming operands and one restoring trial subtract
    always_comb begin
        dividend_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
        divisor_mag  = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
        shifted      = {rem_reg, quo_reg[WIDTH-1]};
        trial        = shifted - {1'b0, dsr_reg};
    end

    // Load on start, then shift/subtract until WIDTH iterations are done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running_reg <= 1'b0;
            cnt_reg     <= '0;
            quo_reg     <= '0;
            rem_reg     <= '0;
            dsr_reg     <= '0;
            dvd_reg     <= '0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            dz_reg      <= 1'b0;
        end else if (start) begin
            running_reg <= 1'b1;
            cnt_reg     <= '0;
            quo_reg     <= dividend_mag;
            rem_reg     <= '0;
            dsr_reg     <= divisor_mag;
            dvd_reg     <= dividend;
            neg_q_reg   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r_reg   <= dividend[WIDTH-1];
            dz_reg      <= (divisor == '0);
        end else if (running_reg) begin
            if (cnt_reg != CW'(WIDTH)) begin
                cnt_reg <= cnt_reg + CW'(1);
                if (!trial[WIDTH]) begin
                    rem_reg <= trial[WIDTH-1:0];
                    quo_reg <= {quo_reg[WIDTH-2:0], 1'b1};
                end else begin
                    rem_reg <= shifted[WIDTH-1:0];
                    quo_reg <= {quo_reg[WIDTH-2:0], 1'b0};
                end
            end else begin
                // Sign-fix edge: the core captures the outputs below now
                running_reg <= 1'b0;
            end
        end
    end

    // Sign fix; a zero divisor forces all-ones quotient and echoes the dividend
    always_comb begin
        done      = running_reg && (cnt_reg == CW'(WIDTH));
        dz        = dz_reg;
        quotient  = neg_q_reg ? (~quo_reg + 1'b1) : quo_reg;
        remainder = neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;
        if (dz_reg) begin
            quotient  = '1;
            remainder = dvd_reg;
        end
    end

endmodule

// File: rtl/alu_seq_core.sv
// Handshaked 8-op signed ALU: one command in flight, single-cycle ops
// finish in EXEC, division runs in the restoring divider during DIV.
module alu_seq_core
    import alu_seq_core_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         opcode,
    input  logic [WIDTH-1:0]   inp1,
    input  logic [WIDTH-1:0]   inp2,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               div_by_zero,
    output logic               busy
);
    state_e                    state_reg;
    state_e                    state_next;
    opcode_e                   op_reg;
    logic [WIDTH-1:0]          a_reg;
    logic [WIDTH-1:0]          b_reg;
    logic [2*WIDTH-1:0]        result_reg;
    logic                      dz_reg;

    logic                      accept;
    logic                      div_start;
    logic                      div_done;
    logic [WIDTH-1:0]          div_quo;
    logic [WIDTH-1:0]          div_rem;
    logic                      div_dz;
    logic signed [2*WIDTH-1:0] a_ext;
    logic signed [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0]        alu_res;

    assign accept    = (state_reg == S_IDLE) && req_valid;
    assign div_start = accept && (opcode == OP_DIV);

    // The divider takes its operands straight off the handshake edge
    alu_seq_divider #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (inp1),
        .divisor   (inp2),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem),
        .dz        (div_dz)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (req_valid) state_next = (opcode == OP_DIV) ? S_DIV : S_EXEC;
            S_EXEC: state_next = S_DONE;
            S_DIV:  if (div_done) state_next = S_DONE;
            S_DONE: if (resp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Operand capture, only at the request handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_reg <= OP_ADD;
            a_reg  <= '0;
            b_reg  <= '0;
        end else if (accept) begin
            op_reg <= opcode_e'(opcode);
            a_reg  <= inp1;
            b_reg  <= inp2;
        end
    end

    // Single-cycle datapath on sign-extended operands
    always_comb begin
        a_ext   = {{WIDTH{a_reg[WIDTH-1]}}, a_reg};
        b_ext   = {{WIDTH{b_reg[WIDTH-1]}}, b_reg};
        alu_res = '0;
        case (op_reg)
            OP_ADD:  alu_res = a_ext + b_ext;
            OP_SUB:  alu_res = a_ext - b_ext;
            OP_MUL:  alu_res = a_ext * b_ext;
            OP_OR:   alu_res = {{WIDTH{1'b0}}, a_reg | b_reg};
            OP_AND:  alu_res = {{WIDTH{1'b0}}, a_reg & b_reg};
            OP_NOT1: alu_res = {{WIDTH{1'b0}}, ~a_reg};
            OP_NOT2: alu_res = {{WIDTH{1'b0}}, ~b_reg};
            default: alu_res = '0;
        endcase
    end

    // Output registers, written once per command and held through DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_reg <= '0;
            dz_reg     <= 1'b0;
        end else if (state_reg == S_EXEC) begin
            result_reg <= alu_res;
            dz_reg     <= 1'b0;
        end else if (state_reg == S_DIV && div_done) begin
            result_reg <= {div_quo, div_rem};
            dz_reg     <= div_dz;
        end
    end

    assign req_ready   = (state_reg == S_IDLE);
    assign resp_valid  = (state_reg == S_DONE);
    assign busy        = (state_reg != S_IDLE);
    assign result      = result_reg;
    assign div_by_zero = dz_reg;

endmodule

// File: tb/tb_alu_seq_core.sv
// Randomized and directed check of alu_seq_core against an arithmetic model.
module tb_alu_seq_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  opcode = 3'd0;
    logic [15:0] inp1 = 16'd0;
    logic [15:0] inp2 = 16'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] result;
    logic        div_by_zero;
    logic        busy;

    int tests  = 0;
    int failed = 0;

    alu_seq_core #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .opcode      (opcode),
        .inp1        (inp1),
        .inp2        (inp2),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .result      (result),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain signed integer arithmetic from the opcode definitions
    function automatic void model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [31:0] r, output logic dz);
        int sa, sb, q, m;
        sa = int'($signed(a));
        sb = int'($signed(b));
        dz = 1'b0;
        r  = 32'd0;
        case (op)
            3'd0: r = sa + sb;
            3'd1: r = sa - sb;
            3'd2: r = sa * sb;
            3'd3: begin
                if (sb == 0) begin
                    r  = {16'hFFFF, a};
                    dz = 1'b1;
                end else begin
                    q = sa / sb;
                    m = sa % sb;
                    r = {q[15:0], m[15:0]};
                end
            end
            3'd4: r = {16'h0000, a | b};
            3'd5: r = {16'h0000, a & b};
            3'd6: r = {16'h0000, ~a};
            default: r = {16'h0000, ~b};
        endcase
    endfunction

    // One full command: handshake, latency, result, optional response stall
    task automatic do_cmd(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input int hold, input bit pulse);
        logic [31:0] exp_res;
        logic        exp_dz;
        int          lat, exp_lat, waited;
        model(op, a, b, exp_res, exp_dz);
        exp_lat = (op == 3'd3) ? 17 : 1;
        waited  = 0;
        while (!req_ready && waited < 50) begin
            @(posedge clk); #1; waited++;
        end
        check("ready_before_cmd", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b1; opcode = op; inp1 = a; inp2 = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        opcode = 3'($urandom); inp1 = 16'($urandom); inp2 = 16'($urandom);
        check("ready_low_after_accept", {31'd0, req_ready}, 32'd0);
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        lat = 0;
        while (!resp_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check("latency", lat, exp_lat);
        check("result", result, exp_res);
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, exp_dz});
        for (int i = 0; i < hold; i++) begin
            if (pulse) begin
                req_valid = 1'($urandom); opcode = 3'($urandom);
                inp1 = 16'($urandom); inp2 = 16'($urandom);
            end
            @(posedge clk); #1;
            check("hold_result", result, exp_res);
            check("hold_valid", {31'd0, resp_valid}, 32'd1);
            check("hold_ready_low", {31'd0, req_ready}, 32'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("valid_cleared", {31'd0, resp_valid}, 32'd0);
        check("ready_after_resp", {31'd0, req_ready}, 32'd1);
        $display("[TB] op=%0d a=%h b=%h -> result=%h dz=%0b lat=%0d (exp %h dz=%0b lat=%0d)",
                 op, a, b, result, div_by_zero, lat, exp_res, exp_dz, exp_lat);
    endtask

    function automatic logic [15:0] pick_operand();
        logic [15:0] edges [5];
        edges[0] = 16'h0000; edges[1] = 16'h0001; edges[2] = 16'hFFFF;
        edges[3] = 16'h7FFF; edges[4] = 16'h8000;
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
        return 16'($urandom);
    endfunction

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        do_cmd(3'd0, 16'd7511, 16'd1250, 0, 1'b0);
        do_cmd(3'd0, 16'(-30650), 16'(-20864), 0, 1'b0);
        do_cmd(3'd2, 16'(-30650), 16'(-20864), 0, 1'b0);
        do_cmd(3'd3, 16'd2364, 16'(-1023), 0, 1'b0);
        do_cmd(3'd3, 16'(-9458), 16'd11023, 0, 1'b0);
        do_cmd(3'd3, 16'h8000, 16'hFFFF, 0, 1'b0);
        do_cmd(3'd6, 16'h0F0F, 16'h1234, 5, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            do_cmd(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                   int'($urandom_range(0, 3)), 1'($urandom));
        end

        // Divide by zero leaves dz set, then reset aborts a divide mid-flight
        do_cmd(3'd3, 16'd100, 16'd0, 0, 1'b0);
        @(negedge clk);
        req_valid = 1'b1; opcode = 3'd3; inp1 = 16'd12345; inp2 = 16'd0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_result", result, 32'd0);
        check("abort_dz", {31'd0, div_by_zero}, 32'd0);
        check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("abort_req_ready", {31'd0, req_ready}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            check("no_resp_after_rst", {31'd0, resp_valid}, 32'd0);
        end
        do_cmd(3'd0, 16'd1, 16'd2, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end

endmodule
